// File: rtl/fft_pkg.sv
// Shared configuration, widths and types for fft_peak_search.
// FFT_PEAK_SECOND_EN adds the second-peak fields to result_t.
package fft_pkg;

  localparam int DATAO_BITS = 18;
  localparam int FFT_SIZE   = 256;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  localparam int MAG_W = 2 * DATAO_BITS;
  localparam int IDX_W = ceil_log2(FFT_SIZE);
  localparam int SUM_W = MAG_W + IDX_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  // Travels alongside a bin through the magnitude pipeline.
  typedef struct packed {
    logic             first;
    logic [IDX_W-1:0] idx;
  } bin_tag_t;

  typedef struct packed {
    logic [MAG_W-1:0] peak_mag;
    logic [IDX_W-1:0] peak_idx;
    logic [SUM_W-1:0] frame_sum;
    logic             frame_ov;
`ifdef FFT_PEAK_SECOND_EN
    logic [MAG_W-1:0] peak2_mag;
    logic [IDX_W-1:0] peak2_idx;
`endif
  } result_t;

endpackage

// File: rtl/fft_peak_search_if.sv
// CoreFFT output stream in, per-frame result out (valid/ready).
// PEAK2_* are present only with FFT_PEAK_SECOND_EN.
interface fft_peak_search_if;
  import fft_pkg::*;

  logic signed [DATAO_BITS-1:0] DATAO_RE;
  logic signed [DATAO_BITS-1:0] DATAO_IM;
  logic                         DATAO_VALID;
  logic                         OUTP_READY;
  logic                         OVFLOW_FLAG;

  logic                         RES_VALID;
  logic                         RES_READY;
  logic [MAG_W-1:0]             PEAK_MAG;
  logic [IDX_W-1:0]             PEAK_IDX;
  logic [SUM_W-1:0]             FRAME_SUM;
  logic                         FRAME_OV;
  logic                         RES_DROP;
`ifdef FFT_PEAK_SECOND_EN
  logic [MAG_W-1:0]             PEAK2_MAG;
  logic [IDX_W-1:0]             PEAK2_IDX;
`endif

  modport slave (
    input  DATAO_RE, DATAO_IM, DATAO_VALID, OUTP_READY, OVFLOW_FLAG, RES_READY,
    output RES_VALID, PEAK_MAG, PEAK_IDX, FRAME_SUM, FRAME_OV, RES_DROP
`ifdef FFT_PEAK_SECOND_EN
    , PEAK2_MAG, PEAK2_IDX
`endif
  );

  modport master (
    output DATAO_RE, DATAO_IM, DATAO_VALID, OUTP_READY, OVFLOW_FLAG, RES_READY,
    input  RES_VALID, PEAK_MAG, PEAK_IDX, FRAME_SUM, FRAME_OV, RES_DROP
`ifdef FFT_PEAK_SECOND_EN
    , PEAK2_MAG, PEAK2_IDX
`endif
  );

endinterface

// File: rtl/fft_mag_sq.sv
// Two-stage registered re^2 + im^2; stage 1 squares, stage 2 sums.
module fft_mag_sq #(
  parameter int IN_W = 18
) (
  input  logic                   CLK,
  input  logic                   NGRST,
  input  logic                   CLKEN,
  input  logic signed [IN_W-1:0] re,
  input  logic signed [IN_W-1:0] im,
  output logic [2*IN_W-1:0]      mag
);

  // Sign-extended to full width so the truncated product is the exact square,
  // including (-2^(IN_W-1))^2.
  logic signed [2*IN_W-1:0] re_x, im_x;
  logic [2*IN_W-1:0]        re_sq, im_sq;

  assign re_x = {{IN_W{re[IN_W-1]}}, re};
  assign im_x = {{IN_W{im[IN_W-1]}}, im};

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      re_sq <= '0;
      im_sq <= '0;
      mag   <= '0;
    end else if (CLKEN) begin
      re_sq <= re_x * re_x;
      im_sq <= im_x * im_x;
      mag   <= re_sq + im_sq;
    end
  end

endmodule

// File: rtl/fft_peak_search.sv
// Per-frame peak bin, peak magnitude and energy of the CoreFFT output stream.
// FFT_PEAK_SECOND_EN additionally tracks the second-largest bin.
module fft_peak_search
  import fft_pkg::*;
(
  input logic              CLK,
  input logic              NGRST,
  input logic              CLKEN,
  fft_peak_search_if.slave bus
);

  localparam int               STAGES   = 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE - 1);

  state_e                 state;
  logic [IDX_W-1:0]       cnt;
  logic [1:0]             dcnt;
  logic                   ov_acc;

  logic [STAGES:0]        vld_pipe;
  bin_tag_t [STAGES:0]    tag_pipe;
  bin_tag_t               tag_in;
  logic [IDX_W-1:0]       idx_in;
  logic [MAG_W-1:0]       mag;

  logic [MAG_W-1:0]       pk_mag;
  logic [IDX_W-1:0]       pk_idx;
  logic [SUM_W-1:0]       sum;
`ifdef FFT_PEAK_SECOND_EN
  logic [MAG_W-1:0]       pk2_mag;
  logic [IDX_W-1:0]       pk2_idx;
`endif

  result_t                res_q;
  logic                   res_vld;
  logic                   res_drop;

  logic start, acc, last, done, take;

  always_comb begin
    start  = bus.OUTP_READY;
    acc    = bus.DATAO_VALID & (start | (state == ACCUM));
    idx_in = start ? '0 : cnt;
    tag_in = '{first: (idx_in == '0), idx: idx_in};
    last   = acc & ~start & (cnt == LAST_IDX);
    done   = (state == DRAIN) & (dcnt == 2'd2) & ~start;
    take   = res_vld & bus.RES_READY;
  end

  fft_mag_sq #(.IN_W(DATAO_BITS)) u_mag (
    .CLK   (CLK),
    .NGRST (NGRST),
    .CLKEN (CLKEN),
    .re    (bus.DATAO_RE),
    .im    (bus.DATAO_IM),
    .mag   (mag)
  );

  // Frame control: OUTP_READY restarts from any state, which is also the abort path.
  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state  <= IDLE;
      cnt    <= '0;
      dcnt   <= '0;
      ov_acc <= 1'b0;
    end else if (CLKEN) begin
      if (start) begin
        state  <= ACCUM;
        cnt    <= IDX_W'(bus.DATAO_VALID);
        dcnt   <= '0;
        ov_acc <= bus.OVFLOW_FLAG;
      end else begin
        unique case (state)
          ACCUM: begin
            ov_acc <= ov_acc | bus.OVFLOW_FLAG;
            if (acc) cnt <= cnt + IDX_W'(1);
            if (last) begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end
          DRAIN: begin
            dcnt <= dcnt + 2'd1;
            if (dcnt == 2'd2) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Tags follow the magnitude pipe; a restart flushes bins of the old frame.
  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (CLKEN) begin
      vld_pipe <= start ? {{STAGES{1'b0}}, acc} : {vld_pipe[STAGES-1:0], acc};
      tag_pipe <= {tag_pipe[STAGES-1:0], tag_in};
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      pk_mag  <= '0;
      pk_idx  <= '0;
      sum     <= '0;
`ifdef FFT_PEAK_SECOND_EN
      pk2_mag <= '0;
      pk2_idx <= '0;
`endif
    end else if (CLKEN) begin
      if (start) begin
        pk_mag  <= '0;
        pk_idx  <= '0;
        sum     <= '0;
`ifdef FFT_PEAK_SECOND_EN
        pk2_mag <= '0;
        pk2_idx <= '0;
`endif
      end else if (vld_pipe[STAGES]) begin
        if (tag_pipe[STAGES].first) begin
          pk_mag  <= mag;
          pk_idx  <= tag_pipe[STAGES].idx;
          sum     <= SUM_W'(mag);
`ifdef FFT_PEAK_SECOND_EN
          pk2_mag <= '0;
          pk2_idx <= '0;
`endif
        end else begin
          sum <= sum + SUM_W'(mag);
          // Strictly greater: on a tie the earlier bin keeps the slot.
          if (mag > pk_mag) begin
            pk_mag  <= mag;
            pk_idx  <= tag_pipe[STAGES].idx;
`ifdef FFT_PEAK_SECOND_EN
            pk2_mag <= pk_mag;
            pk2_idx <= pk_idx;
          end else if (mag > pk2_mag) begin
            pk2_mag <= mag;
            pk2_idx <= tag_pipe[STAGES].idx;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      res_vld  <= 1'b0;
      res_drop <= 1'b0;
      res_q    <= '0;
    end else if (CLKEN) begin
      res_drop <= done & res_vld & ~bus.RES_READY;
      if (done) begin
        res_vld            <= 1'b1;
        res_q.peak_mag     <= pk_mag;
        res_q.peak_idx     <= pk_idx;
        res_q.frame_sum    <= sum;
        res_q.frame_ov     <= ov_acc;
`ifdef FFT_PEAK_SECOND_EN
        res_q.peak2_mag    <= pk2_mag;
        res_q.peak2_idx    <= pk2_idx;
`endif
      end else if (take) begin
        res_vld <= 1'b0;
      end
    end
  end

  assign bus.RES_VALID = res_vld;
  assign bus.RES_DROP  = res_drop;
  assign bus.PEAK_MAG  = res_q.peak_mag;
  assign bus.PEAK_IDX  = res_q.peak_idx;
  assign bus.FRAME_SUM = res_q.frame_sum;
  assign bus.FRAME_OV  = res_q.frame_ov;
`ifdef FFT_PEAK_SECOND_EN
  assign bus.PEAK2_MAG = res_q.peak2_mag;
  assign bus.PEAK2_IDX = res_q.peak2_idx;
`endif

endmodule

// File: tb/tb_fft_peak_search.sv
// Directed bench for fft_peak_search with hand-computed expected results.
module tb_fft_peak_search;
  import fft_pkg::*;

  logic clk   = 1'b0;
  logic ngrst = 1'b0;
  logic clken = 1'b1;

  fft_peak_search_if bus();

  fft_peak_search dut (
    .CLK   (clk),
    .NGRST (ngrst),
    .CLKEN (clken),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int nvalid = 0;
  int re_a [FFT_SIZE];
  int im_a [FFT_SIZE];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.RES_VALID === 1'b1) nvalid++;
  endtask

  task automatic clear_bins(input int re, input int im);
    for (int i = 0; i < FFT_SIZE; i++) begin
      re_a[i] = re;
      im_a[i] = im;
    end
  endtask

  // Bin 0 goes out with OUTP_READY; gaps put an idle cycle with junk data between bins.
  task automatic send(input int nbins, input bit gaps, input int ov_at);
    for (int b = 0; b < nbins; b++) begin
      bus.OUTP_READY  = (b == 0);
      bus.DATAO_VALID = 1'b1;
      bus.DATAO_RE    = DATAO_BITS'(re_a[b]);
      bus.DATAO_IM    = DATAO_BITS'(im_a[b]);
      bus.OVFLOW_FLAG = (b == ov_at);
      tick();
      bus.OUTP_READY  = 1'b0;
      bus.OVFLOW_FLAG = 1'b0;
      if (gaps && b != nbins - 1) begin
        bus.DATAO_VALID = 1'b0;
        bus.DATAO_RE    = DATAO_BITS'(7777);
        bus.DATAO_IM    = DATAO_BITS'(7777);
        tick();
      end
    end
    bus.DATAO_VALID = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.DATAO_RE    = '0;
    bus.DATAO_IM    = '0;
    bus.DATAO_VALID = 1'b0;
    bus.OUTP_READY  = 1'b0;
    bus.OVFLOW_FLAG = 1'b0;
    bus.RES_READY   = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 64'(bus.RES_VALID), 64'd0);
    chk("rst_mag",   64'(bus.PEAK_MAG),  64'd0);
    chk("rst_idx",   64'(bus.PEAK_IDX),  64'd0);
    chk("rst_sum",   64'(bus.FRAME_SUM), 64'd0);
    chk("rst_ov",    64'(bus.FRAME_OV),  64'd0);
    chk("rst_drop",  64'(bus.RES_DROP),  64'd0);
    ngrst = 1'b1;
    tick();

    // Impulse at bin 37, exact latency
    bus.RES_READY = 1'b1;
    clear_bins(0, 0);
    re_a[37] = 1000; im_a[37] = -500;
    send(FFT_SIZE, 1'b0, -1);
    tick(); chk("imp_lat1", 64'(bus.RES_VALID), 64'd0);
    tick(); chk("imp_lat2", 64'(bus.RES_VALID), 64'd0);
    tick(); chk("imp_lat3", 64'(bus.RES_VALID), 64'd1);
    chk("imp_idx",  64'(bus.PEAK_IDX),  64'd37);
    chk("imp_mag",  64'(bus.PEAK_MAG),  64'd1250000);
    chk("imp_sum",  64'(bus.FRAME_SUM), 64'd1250000);
    chk("imp_ov",   64'(bus.FRAME_OV),  64'd0);
    tick(); chk("imp_pulse", 64'(bus.RES_VALID), 64'd0);

    // Tie: lowest index wins
    clear_bins(1, 0);
    re_a[10] = 300; im_a[10] = 400;
    re_a[200] = 300; im_a[200] = 400;
    send(FFT_SIZE, 1'b0, -1);
    repeat (3) tick();
    chk("tie_valid", 64'(bus.RES_VALID), 64'd1);
    chk("tie_idx",   64'(bus.PEAK_IDX),  64'd10);
    chk("tie_mag",   64'(bus.PEAK_MAG),  64'd250000);
    chk("tie_sum",   64'(bus.FRAME_SUM), 64'd500254);
`ifdef FFT_PEAK_SECOND_EN
    chk("tie_mag2",  64'(bus.PEAK2_MAG), 64'd250000);
    chk("tie_idx2",  64'(bus.PEAK2_IDX), 64'd200);
`endif
    tick();

    // Most negative inputs square exactly
    clear_bins(0, 0);
    re_a[0] = -131072; im_a[0] = -131072;
    re_a[5] = -131072;
    send(FFT_SIZE, 1'b0, -1);
    repeat (3) tick();
    chk("ext_idx", 64'(bus.PEAK_IDX),  64'd0);
    chk("ext_mag", 64'(bus.PEAK_MAG),  64'd34359738368);
    chk("ext_sum", 64'(bus.FRAME_SUM), 64'd51539607552);
`ifdef FFT_PEAK_SECOND_EN
    chk("ext_mag2", 64'(bus.PEAK2_MAG), 64'd17179869184);
    chk("ext_idx2", 64'(bus.PEAK2_IDX), 64'd5);
`endif
    tick();

    // Backpressure: frame A held, frame B overwrites with a drop pulse
    bus.RES_READY = 1'b0;
    clear_bins(0, 0);
    re_a[3] = 10;
    send(FFT_SIZE, 1'b0, -1);
    repeat (3) tick();
    chk("bp_a_valid", 64'(bus.RES_VALID), 64'd1);
    chk("bp_a_idx",   64'(bus.PEAK_IDX),  64'd3);
    clear_bins(0, 0);
    im_a[7] = 20;
    send(FFT_SIZE, 1'b0, -1);
    repeat (2) tick();
    chk("bp_hold_idx",  64'(bus.PEAK_IDX), 64'd3);
    chk("bp_hold_drop", 64'(bus.RES_DROP), 64'd0);
    tick();
    chk("bp_b_drop",  64'(bus.RES_DROP),  64'd1);
    chk("bp_b_valid", 64'(bus.RES_VALID), 64'd1);
    chk("bp_b_idx",   64'(bus.PEAK_IDX),  64'd7);
    chk("bp_b_mag",   64'(bus.PEAK_MAG),  64'd400);
    tick();
    chk("bp_drop_1cyc", 64'(bus.RES_DROP), 64'd0);
    chk("bp_b_held",    64'(bus.PEAK_IDX), 64'd7);

    // Completion coincides with acceptance: loads, no drop
    clear_bins(0, 0);
    re_a[9] = -30;
    send(FFT_SIZE, 1'b0, -1);
    repeat (2) tick();
    bus.RES_READY = 1'b1;
    tick();
    chk("same_drop",  64'(bus.RES_DROP),  64'd0);
    chk("same_valid", 64'(bus.RES_VALID), 64'd1);
    chk("same_idx",   64'(bus.PEAK_IDX),  64'd9);
    chk("same_mag",   64'(bus.PEAK_MAG),  64'd900);
    bus.RES_READY = 1'b0;
    repeat (2) tick();
    chk("same_held", 64'(bus.RES_VALID), 64'd1);
    bus.RES_READY = 1'b1;
    tick();
    chk("ready_fall", 64'(bus.RES_VALID), 64'd0);

    // Abort at bin 100, then a gapped frame with one overflow pulse
    nvalid = 0;
    clear_bins(0, 0);
    re_a[98] = 5000; im_a[98] = 5000;
    re_a[99] = 6000;
    send(100, 1'b0, -1);
    clear_bins(0, 0);
    re_a[0] = 1; im_a[0] = 1;
    re_a[20] = 200;
    send(FFT_SIZE, 1'b1, 30);
    repeat (3) tick();
    chk("ab_valid", 64'(bus.RES_VALID), 64'd1);
    chk("ab_idx",   64'(bus.PEAK_IDX),  64'd20);
    chk("ab_mag",   64'(bus.PEAK_MAG),  64'd40000);
    chk("ab_sum",   64'(bus.FRAME_SUM), 64'd40002);
    chk("ab_ov",    64'(bus.FRAME_OV),  64'd1);
    repeat (4) tick();
    chk("ab_count", 64'(nvalid), 64'd1);

    // Reset mid-ACCUM with a result pending
    bus.RES_READY = 1'b0;
    clear_bins(0, 0);
    re_a[4] = 3; im_a[4] = 4;
    send(FFT_SIZE, 1'b0, -1);
    repeat (3) tick();
    chk("pend_valid", 64'(bus.RES_VALID), 64'd1);
    send(50, 1'b0, -1);
    ngrst = 1'b0;
    #1;
    chk("mrst_valid", 64'(bus.RES_VALID), 64'd0);
    chk("mrst_mag",   64'(bus.PEAK_MAG),  64'd0);
    chk("mrst_idx",   64'(bus.PEAK_IDX),  64'd0);
    chk("mrst_sum",   64'(bus.FRAME_SUM), 64'd0);
    tick();
    ngrst = 1'b1;
    // Bins offered in IDLE must be ignored
    bus.DATAO_VALID = 1'b1;
    bus.DATAO_RE    = DATAO_BITS'(9999);
    bus.DATAO_IM    = DATAO_BITS'(9999);
    repeat (4) tick();
    bus.DATAO_VALID = 1'b0;
    bus.RES_READY   = 1'b1;
    re_a[FFT_SIZE-1] = -7; im_a[FFT_SIZE-1] = -24;
    send(FFT_SIZE, 1'b0, -1);
    repeat (2) tick();
    chk("post_lat2", 64'(bus.RES_VALID), 64'd0);
    tick();
    chk("post_valid", 64'(bus.RES_VALID), 64'd1);
    chk("post_idx",   64'(bus.PEAK_IDX),  64'd255);
    chk("post_mag",   64'(bus.PEAK_MAG),  64'd625);
    chk("post_sum",   64'(bus.FRAME_SUM), 64'd650);
    chk("post_ov",    64'(bus.FRAME_OV),  64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_peak_search.md
Name: fft_peak_search

Overview:
- Sits directly downstream of the streaming CoreFFT and consumes its output frame: DATAO_RE/IM, DATAO_VALID, OUTP_READY and OVFLOW_FLAG.
- Computes the squared magnitude of each bin, tracks the peak bin and its index, and accumulates the total frame energy.
- Presents one result per frame on a valid/ready handshake to the GNSS acquisition controller.

Parameters:
- DATAO_BITS, 18, signed width of the FFT output RE/IM samples.
- FFT_SIZE, 256, bins per frame; power of 2, range 16..4096.
- MAG_W, 2*DATAO_BITS, derived; unsigned squared-magnitude width.
- IDX_W, ceil_log2(FFT_SIZE), derived; bin index width.
- SUM_W, MAG_W+IDX_W, derived; frame energy accumulator width.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- NGRST  in  1  asynchronous, active-low reset.
- CLKEN  in  1  global clock enable; when low, all state holds.
- DATAO_RE  in  DATAO_BITS  FFT bin real part, signed.
- DATAO_IM  in  DATAO_BITS  FFT bin imaginary part, signed.
- DATAO_VALID  in  1  bin strobe.
- OUTP_READY  in  1  one-cycle pilot pulse marking the start of a frame.
- OVFLOW_FLAG  in  1  FFT overflow indication.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- PEAK_MAG  out  MAG_W  largest re²+im² in the frame.
- PEAK_IDX  out  IDX_W  bin index of the peak.
- FRAME_SUM  out  SUM_W  sum of all bin magnitudes.
- FRAME_OV  out  1  OVFLOW_FLAG was seen high at any cycle of the frame.
- RES_DROP  out  1  one-cycle pulse: an unconsumed result was overwritten.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters and accumulators 0.
- FSM states: IDLE, ACCUM, DRAIN.
  - IDLE -> ACCUM on OUTP_READY.
  - ACCUM -> DRAIN when bin FFT_SIZE-1 is accepted.
  - DRAIN -> IDLE after 3 cycles.
- Bin acceptance:
  - A bin is accepted when CLKEN & DATAO_VALID are high in ACCUM.
  - It is also accepted on the OUTP_READY cycle itself if DATAO_VALID is high; that bin is bin 0.
  - Bin index = accepted-bin count, 0..FFT_SIZE-1.
- Magnitude pipeline:
  - Stage 1 registers re² and im², each signed×signed with an unsigned result.
  - Stage 2 registers their sum as MAG_W bits, no saturation.
  - Stage 3 compares against the running peak and adds into the sum.
  - The most negative input value, -2^(DATAO_BITS-1), gives the exact square 2^(2·DATAO_BITS-2).
- Peak rule: update on strictly greater, so on a tie the lowest index wins. Bin 0 always loads the peak.
- Latency: the last bin is accepted at cycle t; RES_VALID rises at t+4 with all result fields updated.
- FRAME_OV: sticky OR of OVFLOW_FLAG from OUTP_READY to the last accepted bin.
- Result handshake:
  - The result registers hold and RES_VALID stays high until RES_READY & RES_VALID.
  - After that transfer, RES_VALID drops the next cycle.
  - If a new result completes while RES_VALID is still high, the registers are overwritten, RES_VALID stays high and RES_DROP pulses for one cycle.
  - If completion and acceptance occur in the same cycle, the new result loads and RES_DROP stays 0.
- Abort: OUTP_READY during ACCUM or DRAIN restarts the frame.
  - The bin count and accumulators are cleared.
  - Bins still in the pipeline are discarded, not merged into the new frame.
  - No result is emitted for the aborted frame.
- Partial frame: DATAO_VALID gaps inside ACCUM are legal. A result is only emitted once FFT_SIZE bins have been accepted.
- DATAO_VALID outside ACCUM is ignored.
- Reset mid-operation (NGRST low at any cycle) clears everything immediately, including a pending result.

Optional Feature:
- Macro: FFT_PEAK_SECOND_EN.
- When defined:
  - Adds output PEAK2_MAG (MAG_W bits) and PEAK2_IDX (IDX_W bits): the second-largest magnitude and its index.
  - Update rule when mag > peak: the old peak moves to second, and the new mag becomes the peak.
  - Else, if mag > second, the new mag becomes the second.
  - Ties follow the same strict-greater rule as the peak.
  - Same latency and handshake as the other result fields.
- When undefined: these ports and registers are absent.

Decomposition:
- Shared package fft_pkg:
  - FSM state enum (IDLE/ACCUM/DRAIN).
  - ceil_log2 function.
  - Derived-width constants MAG_W, IDX_W, SUM_W.
- One sub-module: fft_mag_sq, the 2-stage registered re²+im² pipeline with a CLKEN input. The top block holds the FSM, peak tracking and handshake.

Test Plan:
- Impulse: FFT_SIZE=256, bin 37 = (1000,-500), all others 0, RES_READY=1 -> PEAK_IDX=37, PEAK_MAG=1250000, FRAME_SUM=1250000, RES_VALID pulses at t+4.
- Tie: bins 10 and 200 both (300,400), rest (1,0) -> PEAK_IDX=10, PEAK_MAG=250000, FRAME_SUM=500254.
- Extreme value: bin 0 = (-131072,-131072), DATAO_BITS=18 -> PEAK_MAG=2^35 exactly, PEAK_IDX=0.
- Backpressure: RES_READY=0 across two complete frames -> RES_DROP pulses once; the second frame's result is held; RES_VALID falls one cycle after RES_READY.
- Abort plus gaps: OUTP_READY reasserted at bin 100, then a full frame with DATAO_VALID toggling 1/0 -> exactly one result, computed from the second frame only. OVFLOW_FLAG pulsed once in the second frame -> FRAME_OV=1.
- Reset: NGRST low mid-ACCUM and with a pending result -> all outputs 0 immediately; the next full frame produces a correct result.
